// File: rtl/bfm_apb_cmd_master_if.sv
// Bus bundle for bfm_apb_cmd_master: command push port, PM-side APB master
// port, response strobe and status/accounting outputs.
// The master modport is the command engine's view; the slave modport is the
// view of whatever sits on the other side (command source plus APB target).
//
// Handshake rules, in one place:
//   cmd_valid/cmd_ready : a command is taken on a PCLK_PM rising edge where
//                         both are high. cmd_ready only reflects "FIFO not
//                         full"; a source may hold cmd_valid while cmd_ready
//                         is low and nothing is consumed.
//   PENABLE_PM/PREADY_PM: a transfer starts on a PENABLE_PM rising edge and
//                         ends on the edge where PREADY_PM is sampled high
//                         (PSLVERR_PM/PRDATA_PM are valid only with it).
//   rsp_valid           : one-cycle strobe, one per command, no backpressure.
interface bfm_apb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] cmd_mask;

  logic [31:0] PADDR_PM;
  logic        PWRITE_PM;
  logic        PENABLE_PM;
  logic [31:0] PWDATA_PM;
  logic [31:0] PRDATA_PM;
  logic        PREADY_PM;
  logic        PSLVERR_PM;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        timeout;
  logic [15:0] err_count;
  logic [15:0] lat_last;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    input  PRDATA_PM, PREADY_PM, PSLVERR_PM,
    output cmd_ready,
    output PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
    output rsp_valid, rsp_rdata, rsp_err, busy, timeout, err_count, lat_last
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    output PRDATA_PM, PREADY_PM, PSLVERR_PM,
    input  cmd_ready,
    input  PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM,
    input  rsp_valid, rsp_rdata, rsp_err, busy, timeout, err_count, lat_last
  );
endinterface

// File: rtl/bfm_apb_cmd_master.sv
// bfm_apb_cmd_master: APB master command engine on the PCLK_PM domain.
// Commands (WRITE, READ, READCHECK, IDLEWAIT) are queued in a small FIFO and
// executed one at a time as APB transfers on the PM-side bus; each command
// produces exactly one rsp_valid strobe. Error/timeout accounting is kept for
// the surrounding testbench.
//
// Optional feature: define BFM_APB_CMD_LATENCY_EN to build the lat_last
// counter (PENABLE_PM-high cycles of the last transfer). Without it lat_last
// is tied to zero.
//
// Reset: PRESETN_PM, asynchronous, active-low. A reset in the middle of a
// transfer drops PENABLE_PM at once and no response is produced.
module bfm_apb_cmd_master #(
  parameter int unsigned FIFO_DEPTH     = 4,    // power of 2, >= 2
  parameter int unsigned TIMEOUT_CYCLES = 1024  // 1..65535
) (
  input  logic                 PCLK_PM,
  input  logic                 PRESETN_PM,
  bfm_apb_cmd_master_if.master bus,
  output logic [1:0]           o_dbg_state
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL_C = CNT_W'(FIFO_DEPTH);
  // ACCESS cycle index (0-based) at which an unanswered transfer is abandoned
  localparam logic [15:0] TO_LAST_C = 16'(TIMEOUT_CYCLES - 1);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  // Command opcodes
  localparam logic [1:0] OP_WRITE    = 2'd0;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_RDCHECK  = 2'd2;
  localparam logic [1:0] OP_IDLEWAIT = 2'd3;

  // Command FIFO storage and pointers
  logic [1:0]       r_fifo_op   [FIFO_DEPTH];
  logic [31:0]      r_fifo_addr [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [31:0]      r_fifo_mask [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Execution state
  logic [1:0]  r_state;
  logic [1:0]  r_op;
  logic [31:0] r_exp;
  logic [31:0] r_mask;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_acc_cnt;

  // APB master outputs
  logic [31:0] r_paddr;
  logic        r_pwrite;
  logic        r_penable;
  logic [31:0] r_pwdata;

  // Response and accounting outputs
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_timeout;
  logic [15:0] r_err_count;

  // Decodes
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_head_op;
  logic [31:0] w_head_addr;
  logic [31:0] w_head_data;
  logic [31:0] w_head_mask;
  logic        w_acc_ready;
  logic        w_acc_to;
  logic        w_xfer_err;
  logic        w_rsp_err_evt;

  assign w_full  = (r_count == FIFO_FULL_C);
  assign w_empty = (r_count == '0);
  // A push against a full FIFO is dropped even if IDLE pops in that cycle:
  // acceptance depends only on the registered occupancy.
  assign w_push  = bus.cmd_valid && !w_full;
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;

  assign w_head_op   = r_fifo_op[r_rd_ptr];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_mask = r_fifo_mask[r_rd_ptr];

  assign w_acc_ready = (r_state == ST_ACCESS) && bus.PREADY_PM;
  assign w_acc_to    = (r_state == ST_ACCESS) && !bus.PREADY_PM &&
                       (r_acc_cnt == TO_LAST_C);
  // Only READCHECK compares data; the mask selects the bits that matter.
  assign w_xfer_err  = bus.PSLVERR_PM ||
                       ((r_op == OP_RDCHECK) &&
                        ((bus.PRDATA_PM & r_mask) != (r_exp & r_mask)));
  assign w_rsp_err_evt = (w_acc_ready && w_xfer_err) || w_acc_to;

  // Store pushed commands; storage needs no reset since pointers guard it
  always_ff @(posedge PCLK_PM) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr]   <= bus.cmd_op;
      r_fifo_addr[r_wr_ptr] <= bus.cmd_addr;
      r_fifo_data[r_wr_ptr] <= bus.cmd_data;
      r_fifo_mask[r_wr_ptr] <= bus.cmd_mask;
    end
  end

  // FIFO pointers (wrap modulo FIFO_DEPTH) and occupancy
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Command execution FSM: APB sequencing, idle waits and response strobe
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WRITE;
      r_exp       <= '0;
      r_mask      <= '0;
      r_wait_cnt  <= '0;
      r_acc_cnt   <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_op   <= w_head_op;
            r_exp  <= w_head_data;
            r_mask <= w_head_mask;
            if (w_head_op == OP_IDLEWAIT) begin
              r_wait_cnt <= w_head_data[15:0];
              r_state    <= ST_WAIT;
            end else begin
              // Address phase; PENABLE_PM stays low through IDLE and SETUP so
              // consecutive transfers always show a fresh rising edge.
              r_paddr  <= w_head_addr;
              r_pwrite <= (w_head_op == OP_WRITE);
              r_pwdata <= (w_head_op == OP_WRITE) ? w_head_data : 32'h0;
              r_state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_acc_cnt <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.PREADY_PM) begin
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_op == OP_WRITE) ? 32'h0 : bus.PRDATA_PM;
            r_rsp_err   <= w_xfer_err;
            r_state     <= ST_IDLE;
          end else if (w_acc_to) begin
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_acc_cnt <= r_acc_cnt + 16'd1;
          end
        end
        ST_WAIT: begin
          // A count of N occupies N+1 WAIT cycles (zero still costs one).
          if (r_wait_cnt == 16'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of responses flagged with rsp_err
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      r_err_count <= '0;
    end else if (w_rsp_err_evt && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

`ifdef BFM_APB_CMD_LATENCY_EN
  logic [15:0] r_lat_last;

  // Latency of the last transfer: PENABLE_PM-high cycles including PREADY
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      r_lat_last <= '0;
    end else if (w_acc_ready) begin
      r_lat_last <= (r_acc_cnt == 16'hFFFF) ? 16'hFFFF : r_acc_cnt + 16'd1;
    end else if (w_acc_to) begin
      r_lat_last <= 16'(TIMEOUT_CYCLES);
    end
  end

  assign bus.lat_last = r_lat_last;
`else
  assign bus.lat_last = 16'h0;
`endif

  assign bus.cmd_ready  = !w_full;
  assign bus.busy       = !w_empty || (r_state != ST_IDLE);
  assign bus.PADDR_PM   = r_paddr;
  assign bus.PWRITE_PM  = r_pwrite;
  assign bus.PENABLE_PM = r_penable;
  assign bus.PWDATA_PM  = r_pwdata;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.timeout    = r_timeout;
  assign bus.err_count  = r_err_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bfm_apb_cmd_master.sv
// Testbench for bfm_apb_cmd_master: directed steps followed by a randomized
// command stream, with a responding APB target model and a response
// scoreboard. Honours BFM_APB_CMD_LATENCY_EN for lat_last expectations.
module tb_bfm_apb_cmd_master;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef struct {
    logic [31:0] addr;
    logic        pwrite;
    logic [31:0] pwdata;
  } xfer_t;

  typedef struct {
    int          dly;     // ACCESS cycles before the PREADY cycle; -1 = never
    logic [31:0] rdata;
    logic        slverr;
  } beh_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic        upd_lat;
    logic [15:0] lat;
  } rsp_t;

  // ---------------- clock / reset ----------------
  logic PCLK_PM    = 1'b0;
  logic PRESETN_PM = 1'b0;
  logic [1:0] dbg_state;
  int cyc = 0;

  always #5 PCLK_PM = ~PCLK_PM;
  always @(posedge PCLK_PM) cyc <= cyc + 1;

  bfm_apb_cmd_master_if bus();

  bfm_apb_cmd_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK_PM     (PCLK_PM),
    .PRESETN_PM  (PRESETN_PM),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  xfer_t xfer_q[$];
  beh_t  beh_q[$];
  rsp_t  rsp_q[$];
  int    rsp_t_q[$];
  logic [15:0] m_err_count = '0;
  logic        m_timeout   = 1'b0;
  logic [15:0] m_lat       = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: what each accepted command must do on the bus and return
  task automatic model_cmd(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] mask,
                           input beh_t b);
    rsp_t r;
    xfer_t x;
    r = '{rdata: 32'h0, err: 1'b0, to: 1'b0, upd_lat: 1'b0, lat: 16'h0};
    if (op != 2'd3) begin
      x.addr   = addr;
      x.pwrite = (op == 2'd0);
      x.pwdata = (op == 2'd0) ? data : 32'h0;
      xfer_q.push_back(x);
      beh_q.push_back(b);
      r.upd_lat = 1'b1;
      if (b.dly < 0) begin
        r.err = 1'b1;
        r.to  = 1'b1;
        r.lat = 16'(TO);
      end else begin
        r.rdata = (op == 2'd0) ? 32'h0 : b.rdata;
        r.err   = b.slverr || ((op == 2'd2) && ((b.rdata & mask) != (data & mask)));
        r.lat   = 16'(b.dly + 1);
      end
    end
    rsp_q.push_back(r);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic push(input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] mask,
                      input beh_t b, input logic exp_acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_mask  = mask;
    check("cmd_ready", {31'h0, bus.cmd_ready}, {31'h0, exp_acc});
    if (exp_acc) model_cmd(op, addr, data, mask, b);
    @(negedge PCLK_PM);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_ready(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] mask,
                            input beh_t b);
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge PCLK_PM);
      n++;
    end
    check("push_wait_ready", {31'h0, bus.cmd_ready}, 32'h1);
    push(op, addr, data, mask, b, 1'b1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge PCLK_PM);
      n++;
    end
    check(tag, {31'h0, (rsp_q.size() == 0 && !bus.busy)}, 32'h1);
  endtask

  // ---------------- APB target model ----------------
  bit    s_prev_en = 1'b0;
  bit    s_active  = 1'b0;
  bit    s_seen    = 1'b0;
  int    s_k       = 0;
  int    s_low     = 0;
  beh_t  s_b;
  xfer_t s_x;
  logic  s_rdy;

  initial begin : apb_target
    bus.PREADY_PM  = 1'b0;
    bus.PSLVERR_PM = 1'b0;
    bus.PRDATA_PM  = 32'h0;
    s_b = '{dly: 0, rdata: 32'h0, slverr: 1'b0};
    s_x = '{addr: 32'h0, pwrite: 1'b0, pwdata: 32'h0};
    forever begin
      @(negedge PCLK_PM);
      if (!PRESETN_PM) begin
        s_prev_en = 1'b0;
        s_active  = 1'b0;
        s_seen    = 1'b0;
        s_low     = 0;
        bus.PREADY_PM  = 1'b0;
        bus.PSLVERR_PM = 1'b0;
      end else begin
        if (bus.PENABLE_PM && !s_prev_en) begin
          if (s_seen) check("penable_low_gap_ge2", {31'h0, (s_low >= 2)}, 32'h1);
          s_seen = 1'b1;
          check("xfer_expected", {31'h0, (xfer_q.size() != 0)}, 32'h1);
          if (xfer_q.size() != 0) s_x = xfer_q.pop_front();
          else s_x = '{addr: 32'h0, pwrite: 1'b0, pwdata: 32'h0};
          if (beh_q.size() != 0) s_b = beh_q.pop_front();
          else s_b = '{dly: 0, rdata: 32'h0, slverr: 1'b0};
          s_active = 1'b1;
          s_k = 0;
        end
        if (bus.PENABLE_PM) begin
          s_k++;
          check("paddr", bus.PADDR_PM, s_x.addr);
          check("pwrite", {31'h0, bus.PWRITE_PM}, {31'h0, s_x.pwrite});
          check("pwdata", bus.PWDATA_PM, s_x.pwdata);
          s_rdy = (s_b.dly >= 0) && (s_k == s_b.dly + 1);
          bus.PREADY_PM  = s_rdy;
          bus.PSLVERR_PM = s_rdy ? s_b.slverr : 1'($urandom_range(0, 1));
          bus.PRDATA_PM  = s_rdy ? s_b.rdata : $urandom;
          s_low = 0;
        end else begin
          if (s_active) begin
            if (s_b.dly < 0) check("timeout_access_cycles", 32'(s_k), 32'(TO));
            else             check("access_cycles", 32'(s_k), 32'(s_b.dly + 1));
            s_active = 1'b0;
          end
          s_low++;
          bus.PREADY_PM  = 1'b0;
          bus.PSLVERR_PM = 1'b0;
          bus.PRDATA_PM  = $urandom;
        end
        s_prev_en = bus.PENABLE_PM;
      end
    end
  end

  // ---------------- response scoreboard ----------------
  rsp_t m_r;

  initial begin : rsp_monitor
    forever begin
      @(negedge PCLK_PM);
      if (PRESETN_PM && bus.rsp_valid) begin
        rsp_t_q.push_back(cyc);
        check("rsp_expected", {31'h0, (rsp_q.size() != 0)}, 32'h1);
        if (rsp_q.size() != 0) begin
          m_r = rsp_q.pop_front();
          if (m_r.err && m_err_count != 16'hFFFF) m_err_count = m_err_count + 16'd1;
          if (m_r.to) m_timeout = 1'b1;
          if (m_r.upd_lat) m_lat = m_r.lat;
          check("rsp_rdata", bus.rsp_rdata, m_r.rdata);
          check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, m_r.err});
          check("err_count", {16'h0, bus.err_count}, {16'h0, m_err_count});
          check("timeout_flag", {31'h0, bus.timeout}, {31'h0, m_timeout});
`ifdef BFM_APB_CMD_LATENCY_EN
          check("lat_last", {16'h0, bus.lat_last}, {16'h0, m_lat});
`else
          check("lat_last_tied0", {16'h0, bus.lat_last}, 32'h0);
`endif
        end
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  beh_t        b;
  beh_t        nob;
  logic [31:0] a;
  logic [31:0] d;
  logic [31:0] m;
  logic [31:0] tmp;
  logic [1:0]  op;

  initial begin : main
    nob = '{dly: 0, rdata: 32'h0, slverr: 1'b0};
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_data  = 32'h0;
    bus.cmd_mask  = 32'h0;
    PRESETN_PM    = 1'b0;
    repeat (3) @(negedge PCLK_PM);

    // Reset state
    check("rst_penable", {31'h0, bus.PENABLE_PM}, 32'h0);
    check("rst_pwrite", {31'h0, bus.PWRITE_PM}, 32'h0);
    check("rst_paddr", bus.PADDR_PM, 32'h0);
    check("rst_pwdata", bus.PWDATA_PM, 32'h0);
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check("rst_timeout", {31'h0, bus.timeout}, 32'h0);
    check("rst_err_count", {16'h0, bus.err_count}, 32'h0);
    check("rst_lat_last", {16'h0, bus.lat_last}, 32'h0);
    check("rst_dbg_state", {30'h0, dbg_state}, 32'h0);
    PRESETN_PM = 1'b1;
    @(negedge PCLK_PM);

    // WRITE, PREADY on 4th ACCESS cycle
    push(2'd0, 32'h0300_0010, 32'hA5A5_5A5A, 32'h0, '{dly: 3, rdata: 32'hDEAD_BEEF, slverr: 1'b0}, 1'b1);
    drain("drain_write", 50);

    // READCHECK pass then mismatch
    push(2'd2, 32'h0100_0004, 32'h1234_00FF, 32'hFFFF_00FF, '{dly: 0, rdata: 32'h1234_AAFF, slverr: 1'b0}, 1'b1);
    push(2'd2, 32'h0100_0004, 32'h1234_00FF, 32'hFFFF_00FF, '{dly: 1, rdata: 32'h1235_00FF, slverr: 1'b0}, 1'b1);
    drain("drain_rdcheck", 50);
    check("err_count_after_rdcheck", {16'h0, bus.err_count}, 32'h1);

    // Overflow: engine parked in a long wait, DEPTH+1 writes offered
    push(2'd3, 32'h0, 32'd20, 32'h0, nob, 1'b1);
    for (int i = 0; i <= DEPTH; i++) begin
      b = '{dly: int'($urandom_range(0, 3)), rdata: $urandom, slverr: 1'b0};
      push(2'd0, 32'h0200_0000 + 32'(i * 4), $urandom, 32'h0, b, (i < DEPTH) ? 1'b1 : 1'b0);
    end
    drain("drain_overflow", 300);

    // Timeout followed by a normal READ
    push(2'd0, 32'h0400_0020, $urandom, 32'h0, '{dly: -1, rdata: 32'h0, slverr: 1'b0}, 1'b1);
    push(2'd1, 32'h0400_0024, 32'h0, 32'h0, '{dly: 2, rdata: $urandom, slverr: 1'b0}, 1'b1);
    drain("drain_timeout", 100);
    check("timeout_sticky", {31'h0, bus.timeout}, 32'h1);

    // IDLEWAIT of 5 between two WRITEs, second gets PSLVERR
    rsp_t_q.delete();
    push(2'd0, 32'h0500_0000, $urandom, 32'h0, '{dly: 1, rdata: $urandom, slverr: 1'b0}, 1'b1);
    push(2'd3, 32'h0, 32'd5, 32'h0, nob, 1'b1);
    push(2'd0, 32'h0500_0004, $urandom, 32'h0, '{dly: 1, rdata: $urandom, slverr: 1'b1}, 1'b1);
    drain("drain_idlewait", 100);
    check("idlewait_rsp_count", 32'(rsp_t_q.size()), 32'd3);
    if (rsp_t_q.size() >= 2)
      check("idlewait_rsp_gap", 32'(rsp_t_q[1] - rsp_t_q[0]), 32'd7);

    // Randomized command stream
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      m   = $urandom;
      tmp = $urandom;
      b.dly    = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
      b.rdata  = $urandom;
      b.slverr = ($urandom_range(0, 7) == 0);
      if (op == 2'd3) begin
        d = {tmp[31:16], 16'($urandom_range(0, 6))};
      end else if (op == 2'd2 && $urandom_range(0, 1) == 1) begin
        d = b.rdata ^ (tmp & ~m);  // masked bits agree
      end else begin
        d = tmp;
      end
      push_ready(op, a, d, m, b);
      repeat ($urandom_range(0, 2)) @(negedge PCLK_PM);
    end
    drain("drain_random", 3000);

    // Reset in the middle of ACCESS with three commands still queued
    for (int i = 0; i < 4; i++)
      push(2'd0, 32'h0600_0000 + 32'(i * 4), $urandom, 32'h0, '{dly: -1, rdata: 32'h0, slverr: 1'b0}, 1'b1);
    repeat (2) @(negedge PCLK_PM);
    check("pre_reset_penable", {31'h0, bus.PENABLE_PM}, 32'h1);
    #2;
    PRESETN_PM = 1'b0;
    #1;
    check("midrst_penable", {31'h0, bus.PENABLE_PM}, 32'h0);
    check("midrst_busy", {31'h0, bus.busy}, 32'h0);
    check("midrst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("midrst_err_count", {16'h0, bus.err_count}, 32'h0);
    check("midrst_timeout", {31'h0, bus.timeout}, 32'h0);
    xfer_q.delete();
    beh_q.delete();
    rsp_q.delete();
    m_err_count = '0;
    m_timeout   = 1'b0;
    m_lat       = '0;
    repeat (3) @(negedge PCLK_PM);
    PRESETN_PM = 1'b1;
    repeat (TO + 10) @(negedge PCLK_PM);
    check("post_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("post_rst_penable", {31'h0, bus.PENABLE_PM}, 32'h0);

    // Recovery after reset
    push(2'd1, 32'h0700_0008, 32'h0, 32'h0, '{dly: 0, rdata: $urandom, slverr: 1'b0}, 1'b1);
    drain("drain_recovery", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
